core_ex_rtl_chunk_dma: RTL and testbench

- Parametrised ESP example accelerator core, successor to the stub DMA32 example core.
- On conf_done, it reads conf_info_len words from memory through the ESP DMA read interface, in chunks of up to CHUNK words, into a local buffer (PLM).
- It applies a per-word mode transform and writes each chunk back through the DMA write interface.
- It pulses acc_done once the whole transfer completes. It sits between the ESP accelerator socket (config registers and DMA) and nothing else.

---
 rtl/core_ex_rtl_chunk_dma_pkg.sv | 27 ++
 rtl/core_ex_rtl_chunk_dma_plm.sv | 23 ++
 rtl/core_ex_rtl_chunk_dma.sv | 166 ++++++++++++++++
 tb/tb_core_ex_rtl_chunk_dma.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ex_rtl_chunk_dma_pkg.sv
// Shared encodings for the chunked DMA example core: FSM states, transform modes,
// DMA size codes and the request record driven on the ctrl channels.
package core_ex_rtl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_DATA = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_INC  = 2'd1;
    localparam logic [1:0] MODE_INV  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [2:0] SIZE_DWORD = 3'b011;

    typedef struct packed {
        logic [31:0] index;
        logic [31:0] length;
    } dma_req_t;

endpackage

// File: rtl/core_ex_rtl_chunk_dma_plm.sv
// Chunk buffer: CHUNK x DATA_WIDTH registers, one write port, combinational read.
module core_ex_rtl_plm #(
    parameter int DATA_WIDTH = 32,
    parameter int CHUNK      = 16,
    parameter int CHUNK_LOG  = $clog2(CHUNK)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [CHUNK_LOG-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [CHUNK_LOG-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [CHUNK];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/core_ex_rtl_chunk_dma.sv
// Chunked DMA example core: read up to CHUNK words into the PLM, transform,
// write back, repeat until conf_info_len words are done, then pulse acc_done.
module core_ex_rtl_chunk_dma
    import core_ex_rtl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CHUNK      = 16,
    parameter int CHUNK_LOG  = $clog2(CHUNK)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           conf_info_len,
    input  logic [31:0]           conf_info_src_offset,
    input  logic [31:0]           conf_info_dst_offset,
    input  logic [1:0]            conf_info_mode,
    input  logic                  conf_done,
    output logic                  dma_read_ctrl_valid,
    input  logic                  dma_read_ctrl_ready,
    output logic [31:0]           dma_read_ctrl_data_index,
    output logic [31:0]           dma_read_ctrl_data_length,
    output logic [2:0]            dma_read_ctrl_data_size,
    input  logic                  dma_read_chnl_valid,
    output logic                  dma_read_chnl_ready,
    input  logic [DATA_WIDTH-1:0] dma_read_chnl_data,
    output logic                  dma_write_ctrl_valid,
    input  logic                  dma_write_ctrl_ready,
    output logic [31:0]           dma_write_ctrl_data_index,
    output logic [31:0]           dma_write_ctrl_data_length,
    output logic [2:0]            dma_write_ctrl_data_size,
    output logic                  dma_write_chnl_valid,
    input  logic                  dma_write_chnl_ready,
    output logic [DATA_WIDTH-1:0] dma_write_chnl_data,
    output logic                  acc_done,
    output logic [31:0]           debug
);

    localparam int         CW   = CHUNK_LOG + 1;
    localparam logic [2:0] SIZE = (DATA_WIDTH == 64) ? SIZE_DWORD : SIZE_WORD;

    state_t                state;
    logic [31:0]           src_r, dst_r, remaining, offset;
    logic [1:0]            mode_r;
    logic [CW-1:0]         wcnt, rcnt, clen, last_beat;
    logic                  rd_req_v, rd_chnl_r, wr_req_v, wr_chnl_v, done_r;
    logic [DATA_WIDTH-1:0] plm_rdata;
    dma_req_t              rd_req, wr_req;

    function automatic logic [DATA_WIDTH-1:0] xform(input logic [1:0] m,
                                                    input logic [DATA_WIDTH-1:0] x);
        case (m)
            MODE_INC: return x + DATA_WIDTH'(1);
            MODE_INV: return ~x;
            default:  return x;
        endcase
    endfunction

    // remaining only moves at chunk boundaries, so clen is stable for a whole chunk
    assign clen      = (remaining >= 32'(CHUNK)) ? CW'(CHUNK) : remaining[CW-1:0];
    assign last_beat = clen - CW'(1);

    assign rd_req = '{index: src_r + offset, length: 32'(clen)};
    assign wr_req = '{index: dst_r + offset, length: 32'(clen)};

    core_ex_rtl_plm #(
        .DATA_WIDTH (DATA_WIDTH),
        .CHUNK      (CHUNK),
        .CHUNK_LOG  (CHUNK_LOG)
    ) u_plm (
        .clk   (clk),
        .we    (rd_chnl_r && dma_read_chnl_valid),
        .waddr (wcnt[CHUNK_LOG-1:0]),
        .wdata (dma_read_chnl_data),
        .raddr (rcnt[CHUNK_LOG-1:0]),
        .rdata (plm_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            src_r     <= '0;
            dst_r     <= '0;
            mode_r    <= '0;
            remaining <= '0;
            offset    <= '0;
            wcnt      <= '0;
            rcnt      <= '0;
            rd_req_v  <= 1'b0;
            rd_chnl_r <= 1'b0;
            wr_req_v  <= 1'b0;
            wr_chnl_v <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: if (conf_done) begin
                    src_r     <= conf_info_src_offset;
                    dst_r     <= conf_info_dst_offset;
                    mode_r    <= conf_info_mode;
                    remaining <= conf_info_len;
                    offset    <= '0;
                    if (conf_info_len == 32'd0) begin
                        state <= S_DONE;
                    end else begin
                        state    <= S_RD_REQ;
                        rd_req_v <= 1'b1;
                    end
                end
                S_RD_REQ: if (dma_read_ctrl_ready) begin
                    rd_req_v  <= 1'b0;
                    rd_chnl_r <= 1'b1;
                    wcnt      <= '0;
                    state     <= S_RD_DATA;
                end
                S_RD_DATA: if (dma_read_chnl_valid && rd_chnl_r) begin
                    wcnt <= wcnt + CW'(1);
                    if (wcnt == last_beat) begin
                        rd_chnl_r <= 1'b0;
                        wr_req_v  <= 1'b1;
                        state     <= S_WR_REQ;
                    end
                end
                S_WR_REQ: if (dma_write_ctrl_ready) begin
                    wr_req_v  <= 1'b0;
                    wr_chnl_v <= 1'b1;
                    rcnt      <= '0;
                    state     <= S_WR_DATA;
                end
                S_WR_DATA: if (dma_write_chnl_ready) begin
                    rcnt <= rcnt + CW'(1);
                    if (rcnt == last_beat) begin
                        wr_chnl_v <= 1'b0;
                        offset    <= offset + 32'(clen);
                        remaining <= remaining - 32'(clen);
                        if (remaining == 32'(clen)) begin
                            state <= S_DONE;
                        end else begin
                            state    <= S_RD_REQ;
                            rd_req_v <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done_r <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // request fields and write data read zero whenever their valid is low
    assign dma_read_ctrl_valid        = rd_req_v;
    assign dma_read_ctrl_data_index   = rd_req_v ? rd_req.index  : '0;
    assign dma_read_ctrl_data_length  = rd_req_v ? rd_req.length : '0;
    assign dma_read_ctrl_data_size    = rd_req_v ? SIZE : 3'b000;
    assign dma_read_chnl_ready        = rd_chnl_r;
    assign dma_write_ctrl_valid       = wr_req_v;
    assign dma_write_ctrl_data_index  = wr_req_v ? wr_req.index  : '0;
    assign dma_write_ctrl_data_length = wr_req_v ? wr_req.length : '0;
    assign dma_write_ctrl_data_size   = wr_req_v ? SIZE : 3'b000;
    assign dma_write_chnl_valid       = wr_chnl_v;
    assign dma_write_chnl_data        = wr_chnl_v ? xform(mode_r, plm_rdata) : '0;
    assign acc_done                   = done_r;
    assign debug                      = {29'd0, state};

endmodule

// File: tb/tb_core_ex_rtl_chunk_dma.sv
// Self-checking bench: DMA responder + scoreboard queues of expected requests and write data.
module tb_core_ex_rtl_chunk_dma;

    localparam int DW = 32;
    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   conf_info_len, conf_info_src_offset, conf_info_dst_offset;
    logic [1:0]    conf_info_mode;
    logic          conf_done;
    logic          dma_read_ctrl_valid, dma_read_ctrl_ready;
    logic [31:0]   dma_read_ctrl_data_index, dma_read_ctrl_data_length;
    logic [2:0]    dma_read_ctrl_data_size;
    logic          dma_read_chnl_valid, dma_read_chnl_ready;
    logic [DW-1:0] dma_read_chnl_data;
    logic          dma_write_ctrl_valid, dma_write_ctrl_ready;
    logic [31:0]   dma_write_ctrl_data_index, dma_write_ctrl_data_length;
    logic [2:0]    dma_write_ctrl_data_size;
    logic          dma_write_chnl_valid, dma_write_chnl_ready;
    logic [DW-1:0] dma_write_chnl_data;
    logic          acc_done;
    logic [31:0]   debug;

    core_ex_rtl_chunk_dma #(.DATA_WIDTH(DW), .CHUNK(CH)) dut (
        .clk(clk), .rst(rst),
        .conf_info_len(conf_info_len), .conf_info_src_offset(conf_info_src_offset),
        .conf_info_dst_offset(conf_info_dst_offset), .conf_info_mode(conf_info_mode),
        .conf_done(conf_done),
        .dma_read_ctrl_valid(dma_read_ctrl_valid), .dma_read_ctrl_ready(dma_read_ctrl_ready),
        .dma_read_ctrl_data_index(dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size(dma_read_ctrl_data_size),
        .dma_read_chnl_valid(dma_read_chnl_valid), .dma_read_chnl_ready(dma_read_chnl_ready),
        .dma_read_chnl_data(dma_read_chnl_data),
        .dma_write_ctrl_valid(dma_write_ctrl_valid), .dma_write_ctrl_ready(dma_write_ctrl_ready),
        .dma_write_ctrl_data_index(dma_write_ctrl_data_index),
        .dma_write_ctrl_data_length(dma_write_ctrl_data_length),
        .dma_write_ctrl_data_size(dma_write_ctrl_data_size),
        .dma_write_chnl_valid(dma_write_chnl_valid), .dma_write_chnl_ready(dma_write_chnl_ready),
        .dma_write_chnl_data(dma_write_chnl_data),
        .acc_done(acc_done), .debug(debug)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, acc_cnt = 0, acc_cyc = -1, ctrl_vld_cnt = 0, extra = 0;
    bit stall = 0, rd_hold = 0;
    bit p_rq_st = 0, p_wq_st = 0, p_wc_st = 0;
    logic [63:0] p_rq, p_wq;
    logic [DW-1:0] p_wdata;
    logic [63:0] exp_rreq[$], exp_wreq[$], exp_wdata[$];
    logic [DW-1:0] rd_q[$];
    logic [DW-1:0] mem[int unsigned];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] word(input logic [31:0] idx);
        if (mem.exists(idx)) return mem[idx];
        return (idx * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    function automatic logic [DW-1:0] xf(input logic [1:0] m, input logic [DW-1:0] x);
        if (m == 2'd1) return x + 32'd1;
        if (m == 2'd2) return ~x;
        return x;
    endfunction

    // one clock: sample outputs and drive inputs at negedge, then let the edge happen
    task automatic step();
        logic [63:0] e;
        @(negedge clk);
        cyc++;
        if (p_rq_st) chk("rreq_hold", {dma_read_ctrl_data_index, dma_read_ctrl_data_length}, p_rq);
        if (p_wq_st) chk("wreq_hold", {dma_write_ctrl_data_index, dma_write_ctrl_data_length}, p_wq);
        if (p_wc_st) chk("wdata_hold", {31'd0, dma_write_chnl_valid, dma_write_chnl_data}, {31'd0, 1'b1, p_wdata});
        if (dma_read_ctrl_valid || dma_write_ctrl_valid) ctrl_vld_cnt++;
        if (acc_done) begin acc_cnt++; acc_cyc = cyc; end
        dma_read_ctrl_ready  = stall ? 1'($urandom % 2) : 1'b1;
        dma_write_ctrl_ready = stall ? 1'($urandom % 2) : 1'b1;
        dma_write_chnl_ready = stall ? 1'($urandom % 2) : 1'b1;
        if (!rd_hold) begin
            if (rd_q.size() > 0 && (!stall || ($urandom % 2) == 0)) begin
                dma_read_chnl_valid = 1'b1;
                dma_read_chnl_data  = rd_q[0];
            end else begin
                dma_read_chnl_valid = 1'b0;
            end
        end
        if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
            if (exp_rreq.size() == 0) extra++;
            else begin
                e = exp_rreq.pop_front();
                chk("rreq", {dma_read_ctrl_data_index, dma_read_ctrl_data_length}, e);
            end
            chk("rsize", {61'd0, dma_read_ctrl_data_size}, 64'd2);
            for (int i = 0; i < int'(dma_read_ctrl_data_length) && i < 64; i++)
                rd_q.push_back(word(dma_read_ctrl_data_index + 32'(i)));
        end
        rd_hold = dma_read_chnl_valid && !dma_read_chnl_ready;
        if (dma_read_chnl_valid && dma_read_chnl_ready && rd_q.size() > 0) void'(rd_q.pop_front());
        if (dma_write_ctrl_valid && dma_write_ctrl_ready) begin
            if (exp_wreq.size() == 0) extra++;
            else begin
                e = exp_wreq.pop_front();
                chk("wreq", {dma_write_ctrl_data_index, dma_write_ctrl_data_length}, e);
            end
        end
        if (dma_write_chnl_valid && dma_write_chnl_ready) begin
            if (exp_wdata.size() == 0) extra++;
            else begin
                e = exp_wdata.pop_front();
                chk("wdata", {32'd0, dma_write_chnl_data}, e);
            end
        end
        p_rq_st = dma_read_ctrl_valid && !dma_read_ctrl_ready;
        p_wq_st = dma_write_ctrl_valid && !dma_write_ctrl_ready;
        p_wc_st = dma_write_chnl_valid && !dma_write_chnl_ready;
        p_rq    = {dma_read_ctrl_data_index, dma_read_ctrl_data_length};
        p_wq    = {dma_write_ctrl_data_index, dma_write_ctrl_data_length};
        p_wdata = dma_write_chnl_data;
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        exp_rreq.delete(); exp_wreq.delete(); exp_wdata.delete(); rd_q.delete();
        rd_hold = 0; p_rq_st = 0; p_wq_st = 0; p_wc_st = 0;
        dma_read_chnl_valid = 1'b0;
        acc_cnt = 0; acc_cyc = -1; ctrl_vld_cnt = 0; extra = 0;
    endtask

    // pushes the expected transaction stream, then pulses conf_done for one clock
    task automatic start(input int len, input logic [31:0] src, input logic [31:0] dst,
                         input logic [1:0] mode, output int c0);
        int off, cl;
        flush();
        off = 0;
        while (off < len) begin
            cl = (len - off > CH) ? CH : len - off;
            exp_rreq.push_back({src + 32'(off), 32'(cl)});
            exp_wreq.push_back({dst + 32'(off), 32'(cl)});
            for (int i = 0; i < cl; i++)
                exp_wdata.push_back({32'd0, xf(mode, word(src + 32'(off + i)))});
            off += cl;
        end
        conf_info_len = 32'(len); conf_info_src_offset = src;
        conf_info_dst_offset = dst; conf_info_mode = mode;
        conf_done = 1'b1;
        c0 = cyc + 1;
        step();
        conf_done = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (acc_cnt == 0 && n < budget) begin step(); n++; end
        if (acc_cnt == 0) chk({tag, "_timeout"}, 64'(acc_cnt), 64'd1);
        repeat (6) step();
    endtask

    task automatic wait_state(input string tag, input logic [31:0] s, input int budget);
        int n = 0;
        while (debug != s && n < budget) begin step(); n++; end
        if (debug != s) chk({tag, "_reach"}, 64'(debug), 64'(s));
    endtask

    task automatic end_checks(input string tag);
        chk({tag, "_acc"},   64'(acc_cnt), 64'd1);
        chk({tag, "_rq"},    64'(exp_rreq.size()), 64'd0);
        chk({tag, "_wq"},    64'(exp_wreq.size()), 64'd0);
        chk({tag, "_wd"},    64'(exp_wdata.size()), 64'd0);
        chk({tag, "_extra"}, 64'(extra), 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vld"}, {59'd0, dma_read_ctrl_valid, dma_read_chnl_ready, dma_write_ctrl_valid,
                            dma_write_chnl_valid, acc_done}, 64'd0);
        chk({tag, "_rdf"}, {29'd0, dma_read_ctrl_data_size, dma_read_ctrl_data_index ^ dma_read_ctrl_data_length}, 64'd0);
        chk({tag, "_wrf"}, {29'd0, dma_write_ctrl_data_size, dma_write_ctrl_data_index | dma_write_ctrl_data_length}, 64'd0);
        chk({tag, "_wd"},  {32'd0, dma_write_chnl_data}, 64'd0);
        chk({tag, "_dbg"}, {32'd0, debug}, 64'd0);
    endtask

    initial begin
        int c0;
        rst = 1'b1; conf_done = 1'b0; conf_info_len = '0; conf_info_src_offset = '0;
        conf_info_dst_offset = '0; conf_info_mode = '0;
        dma_read_ctrl_ready = 1'b0; dma_write_ctrl_ready = 1'b0; dma_write_chnl_ready = 1'b0;
        dma_read_chnl_valid = 1'b0; dma_read_chnl_data = '0;
        mem[32'h300] = 32'hFFFFFFFF; mem[32'h301] = 32'd5; mem[32'h310] = 32'h0000FFFF;
        repeat (3) step();
        chk_zero("reset");
        rst = 1'b0;
        step();

        // zero length: straight to DONE, no requests
        start(0, 32'h10, 32'h20, 2'd0, c0);
        wait_done("len0", 20);
        chk("len0_acc_cyc", 64'(acc_cyc), 64'(c0 + 2));
        chk("len0_ctrl_vld", 64'(ctrl_vld_cnt), 64'd0);
        chk("len0_dbg", {32'd0, debug}, 64'd0);
        end_checks("len0");

        // 10 words over CHUNK=4: two full chunks plus a 2-word tail
        start(10, 32'h100, 32'h200, 2'd0, c0);
        wait_done("len10", 200);
        end_checks("len10");

        // exact multiple of CHUNK: no zero-length tail
        start(8, 32'h180, 32'h280, 2'd3, c0);
        wait_done("len8", 200);
        end_checks("len8");

        start(2, 32'h300, 32'h400, 2'd1, c0);
        wait_done("inc", 100);
        end_checks("inc");

        start(1, 32'h310, 32'h410, 2'd2, c0);
        wait_done("inv", 100);
        end_checks("inv");

        // random stalls on every channel
        stall = 1;
        start(37, 32'h1000, 32'h2000, 2'd1, c0);
        wait_done("stall", 3000);
        end_checks("stall");
        stall = 0;

        // a second conf_done mid-read must be ignored
        start(9, 32'h40, 32'h80, 2'd2, c0);
        wait_state("reconf", 32'd2, 20);
        conf_info_len = 32'd3; conf_info_src_offset = 32'h999;
        conf_info_dst_offset = 32'h777; conf_info_mode = 2'd1;
        conf_done = 1'b1;
        step();
        conf_done = 1'b0;
        wait_done("reconf", 200);
        end_checks("reconf");

        // reset during WR_DATA aborts with no completion pulse
        start(10, 32'h500, 32'h600, 2'd2, c0);
        wait_state("abort", 32'd4, 40);
        rst = 1'b1;
        step();
        chk_zero("abort");
        rst = 1'b0;
        flush();
        repeat (5) step();
        chk("abort_noacc", 64'(acc_cnt), 64'd0);
        start(3, 32'h700, 32'h800, 2'd1, c0);
        wait_done("after", 100);
        end_checks("after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
